// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pkg
//  Purpose  : Shared types, default sizes and helpers for the FFT sequencer
//  Revision : 1.0  initial release
// ============================================================================
package fft_pkg;

    localparam int c_N_POINTS_DFLT = 64;
    localparam int c_LOG2_N_DFLT   = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        UNLOAD  = 2'd3
    } fft_state_t;

    // Reverse the low 'width' bits of value; bits above 'width' come back as zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
        logic [31:0] rev;
        rev = {<<{value}};
        return rev >> (32 - width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_flex_counter.sv
`default_nettype none
// ============================================================================
//  Module   : fft_flex_counter
//  Purpose  : Up-counter with synchronous clear, enable and programmable wrap.
//             rollover_flag_o is high while the count sits at rollover_val_i.
//  Revision : 1.0  initial release
// ============================================================================
module fft_flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             clear_i,
    input  logic             count_enable_i,
    input  logic [WIDTH-1:0] rollover_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             rollover_flag_o
);

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;

    // Next count: clear wins, then wrap at rollover_val_i, otherwise step by one.
    always_comb begin
        w_count_d = r_count_q;
        if (clear_i) begin
            w_count_d = '0;
        end else if (count_enable_i) begin
            if (r_count_q == rollover_val_i) begin
                w_count_d = '0;
            end else begin
                w_count_d = r_count_q + WIDTH'(1);
            end
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign count_o         = r_count_q;
    assign rollover_flag_o = (r_count_q == rollover_val_i);

endmodule
`default_nettype wire

// File: rtl/fft_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fft_seq_ctrl
//  Purpose  : Frame sequencer for the radix-2 FFT datapath. Loads N samples at
//             bit-reversed addresses, issues LOG2_N stages of N/2 butterflies,
//             then streams N results out under valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int N_POINTS = c_N_POINTS_DFLT,
    parameter int LOG2_N   = c_LOG2_N_DFLT
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       input_ena,
    input  logic                       bfly_ready,
    input  logic                       out_ready,
    output logic                       samp_we,
    output logic [LOG2_N-1:0]          samp_addr,
    output logic [LOG2_N:0]            samples_in_count_out,
    output logic                       it_count_strobe,
    output logic                       iter_strobe,
    output logic [$clog2(LOG2_N)-1:0]  stage,
    output logic [LOG2_N-2:0]          bfly_idx,
    output logic                       out_valid,
    output logic [LOG2_N-1:0]          out_addr,
    output logic                       busy,
    output logic                       done
);

    localparam int c_CNT_W   = LOG2_N + 1;
    localparam int c_BFLY_W  = LOG2_N - 1;
    localparam int c_STAGE_W = $clog2(LOG2_N);

    localparam logic [c_CNT_W-1:0]   c_SAMP_ROLL  = c_CNT_W'(N_POINTS);
    localparam logic [c_CNT_W-1:0]   c_SAMP_LAST  = c_CNT_W'(N_POINTS - 1);
    localparam logic [c_BFLY_W-1:0]  c_BFLY_LAST  = c_BFLY_W'(N_POINTS / 2 - 1);
    localparam logic [c_STAGE_W-1:0] c_STAGE_LAST = c_STAGE_W'(LOG2_N - 1);
    localparam logic [LOG2_N-1:0]    c_ADDR_LAST  = LOG2_N'(N_POINTS - 1);

    fft_state_t r_state_q;
    fft_state_t w_state_d;
    logic       r_done_q;
    logic       w_done_d;

    logic [c_CNT_W-1:0]   w_samp_cnt;
    logic [c_BFLY_W-1:0]  w_bfly_cnt;
    logic [c_STAGE_W-1:0] w_stage_cnt;
    logic [LOG2_N-1:0]    w_out_cnt;
    logic                 w_samp_full;
    logic                 w_bfly_wrap;
    logic                 w_stage_wrap;
    logic                 w_out_last;

    logic w_in_idle;
    logic w_in_load;
    logic w_in_comp;
    logic w_in_unl;
    logic w_frame_start;
    logic w_clear;
    logic w_samp_acc;
    logic w_bfly_iss;
    logic w_last_bfly;
    logic w_last_stage_bfly;
    logic w_out_acc;

    assign w_in_idle = (r_state_q == IDLE);
    assign w_in_load = (r_state_q == LOAD);
    assign w_in_comp = (r_state_q == COMPUTE);
    assign w_in_unl  = (r_state_q == UNLOAD);

    // Every counter restarts from zero on a new frame or on abort.
    assign w_frame_start     = w_in_idle && start && !abort;
    assign w_clear           = abort || w_frame_start;
    assign w_samp_acc        = w_in_load && input_ena && !w_samp_full;
    assign w_bfly_iss        = w_in_comp && bfly_ready;
    assign w_last_bfly       = w_bfly_iss && w_bfly_wrap;
    assign w_last_stage_bfly = w_last_bfly && w_stage_wrap;
    assign w_out_acc         = w_in_unl && out_ready;

    // Samples accepted this frame; parks at N once loading completes.
    fft_flex_counter #(.WIDTH(c_CNT_W)) u_samp_cnt (
        .clk            (clk),
        .n_reset        (n_reset),
        .clear_i        (w_clear),
        .count_enable_i (w_samp_acc),
        .rollover_val_i (c_SAMP_ROLL),
        .count_o        (w_samp_cnt),
        .rollover_flag_o(w_samp_full)
    );

    // Butterfly index within the current stage.
    fft_flex_counter #(.WIDTH(c_BFLY_W)) u_bfly_cnt (
        .clk            (clk),
        .n_reset        (n_reset),
        .clear_i        (w_clear),
        .count_enable_i (w_bfly_iss),
        .rollover_val_i (c_BFLY_LAST),
        .count_o        (w_bfly_cnt),
        .rollover_flag_o(w_bfly_wrap)
    );

    // Stage index; wraps to zero together with the final butterfly.
    fft_flex_counter #(.WIDTH(c_STAGE_W)) u_stage_cnt (
        .clk            (clk),
        .n_reset        (n_reset),
        .clear_i        (w_clear),
        .count_enable_i (w_last_bfly),
        .rollover_val_i (c_STAGE_LAST),
        .count_o        (w_stage_cnt),
        .rollover_flag_o(w_stage_wrap)
    );

    // Result read address; only moves on an accepted output word.
    fft_flex_counter #(.WIDTH(LOG2_N)) u_out_cnt (
        .clk            (clk),
        .n_reset        (n_reset),
        .clear_i        (w_clear),
        .count_enable_i (w_out_acc),
        .rollover_val_i (c_ADDR_LAST),
        .count_o        (w_out_cnt),
        .rollover_flag_o(w_out_last)
    );

    // State and done-pulse registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state_q <= IDLE;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_done_q  <= w_done_d;
        end
    end

    // Phase sequencing; abort overrides every other transition.
    always_comb begin
        w_state_d = r_state_q;
        w_done_d  = 1'b0;
        if (abort) begin
            w_state_d = IDLE;
        end else begin
            case (r_state_q)
                IDLE: begin
                    if (start) begin
                        w_state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (w_samp_acc && (w_samp_cnt == c_SAMP_LAST)) begin
                        w_state_d = COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (w_last_stage_bfly) begin
                        w_state_d = UNLOAD;
                    end
                end
                UNLOAD: begin
                    if (w_out_acc && w_out_last) begin
                        w_state_d = IDLE;
                        w_done_d  = 1'b1;
                    end
                end
                default: begin
                    w_state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode; the sample count is masked in IDLE so all outputs read zero there.
    always_comb begin
        samp_we              = w_samp_acc;
        samp_addr            = '0;
        samples_in_count_out = '0;
        if (w_in_load) begin
            samp_addr = LOG2_N'(bit_reverse(32'(w_samp_cnt[LOG2_N-1:0]), LOG2_N));
        end
        if (!w_in_idle) begin
            samples_in_count_out = w_samp_cnt;
        end
    end

    assign it_count_strobe = w_bfly_iss;
    assign iter_strobe     = w_last_bfly;
    assign stage           = w_stage_cnt;
    assign bfly_idx        = w_bfly_cnt;
    assign out_valid       = w_in_unl;
    assign out_addr        = w_out_cnt;
    assign busy            = !w_in_idle;
    assign done            = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_seq_ctrl
//  Purpose  : Scoreboard bench for fft_seq_ctrl. Expected load addresses,
//             butterfly schedule and output addresses are queued per frame and
//             consumed by a monitor as the DUT produces them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_seq_ctrl;

    localparam int N    = 64;
    localparam int L    = 6;
    localparam int HALF = N / 2;

    logic         clk = 1'b0;
    logic         n_reset;
    logic         start;
    logic         abort;
    logic         input_ena;
    logic         bfly_ready;
    logic         out_ready;
    logic         samp_we;
    logic [L-1:0] samp_addr;
    logic [L:0]   samples_in_count_out;
    logic         it_count_strobe;
    logic         iter_strobe;
    logic [2:0]   stage;
    logic [L-2:0] bfly_idx;
    logic         out_valid;
    logic [L-1:0] out_addr;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    fft_seq_ctrl #(.N_POINTS(N), .LOG2_N(L)) dut (
        .clk                 (clk),
        .n_reset             (n_reset),
        .start               (start),
        .abort               (abort),
        .input_ena           (input_ena),
        .bfly_ready          (bfly_ready),
        .out_ready           (out_ready),
        .samp_we             (samp_we),
        .samp_addr           (samp_addr),
        .samples_in_count_out(samples_in_count_out),
        .it_count_strobe     (it_count_strobe),
        .iter_strobe         (iter_strobe),
        .stage               (stage),
        .bfly_idx            (bfly_idx),
        .out_valid           (out_valid),
        .out_addr            (out_addr),
        .busy                (busy),
        .done                (done)
    );

    int checks = 0;
    int errors = 0;

    int q_ld_addr[$];
    int q_ld_cnt[$];
    int q_cp_stage[$];
    int q_cp_bfly[$];
    int q_cp_iter[$];
    int q_out[$];

    bit exp_idle = 1'b1;
    bit tmo_req  = 1'b0;
    bit done_exp = 1'b0;

    // Reference bit reversal: rebuild the index one bit at a time.
    function automatic int bitrev_ref(input int v, input int w);
        int r;
        r = 0;
        for (int i = 0; i < w; i++) begin
            r = (r << 1) | ((v >> i) & 1);
        end
        return r;
    endfunction

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compare DUT activity against the queued frame expectations.
    always @(negedge clk) begin
        bit nxt_done;
        int a;
        int c;
        nxt_done = 1'b0;
        if (done_exp || done) begin
            chk("done_pulse", int'(done), int'(done_exp));
        end
        if (done_exp) begin
            chk("busy_after_done", int'(busy), 0);
        end
        if (exp_idle) begin
            chk("idle_busy", int'(busy), 0);
            chk("idle_we", int'(samp_we), 0);
            chk("idle_samp_addr", int'(samp_addr), 0);
            chk("idle_count", int'(samples_in_count_out), 0);
            chk("idle_it_strobe", int'(it_count_strobe), 0);
            chk("idle_iter_strobe", int'(iter_strobe), 0);
            chk("idle_stage", int'(stage), 0);
            chk("idle_bfly_idx", int'(bfly_idx), 0);
            chk("idle_out_valid", int'(out_valid), 0);
            chk("idle_out_addr", int'(out_addr), 0);
            chk("leftover_expect", q_ld_addr.size() + q_cp_bfly.size() + q_out.size(), 0);
            chk("frame_timeout", int'(tmo_req), 0);
        end else begin
            // load phase
            if (q_ld_addr.size() > 0) begin
                chk("early_compute", int'(it_count_strobe), 0);
            end
            if (samp_we) begin
                if (q_ld_addr.size() == 0) begin
                    chk("extra_samp_we", int'(samp_we), 0);
                end else begin
                    a = q_ld_addr.pop_front();
                    c = q_ld_cnt.pop_front();
                    chk("ld_samp_addr", int'(samp_addr), a);
                    chk("ld_count", int'(samples_in_count_out), c);
                end
            end else if (q_ld_cnt.size() > 0) begin
                chk("ld_hold_count", int'(samples_in_count_out), q_ld_cnt[0]);
            end else if (busy) begin
                chk("count_full", int'(samples_in_count_out), N);
            end
            // compute phase
            if (it_count_strobe) begin
                if (q_cp_bfly.size() == 0) begin
                    chk("extra_bfly", int'(it_count_strobe), 0);
                end else begin
                    chk("cp_stage", int'(stage), q_cp_stage.pop_front());
                    chk("cp_bfly_idx", int'(bfly_idx), q_cp_bfly.pop_front());
                    chk("cp_iter_strobe", int'(iter_strobe), q_cp_iter.pop_front());
                end
            end else begin
                chk("iter_without_issue", int'(iter_strobe), 0);
                if (q_cp_bfly.size() > 0) begin
                    chk("cp_hold_stage", int'(stage), q_cp_stage[0]);
                    chk("cp_hold_bfly", int'(bfly_idx), q_cp_bfly[0]);
                end else begin
                    chk("post_stage", int'(stage), 0);
                    chk("post_bfly", int'(bfly_idx), 0);
                end
            end
            // unload phase
            if (q_cp_bfly.size() > 0) begin
                chk("early_out_valid", int'(out_valid), 0);
            end
            if (out_valid && out_ready) begin
                if (q_out.size() == 0) begin
                    chk("extra_out", int'(out_valid), 0);
                end else begin
                    a = q_out.pop_front();
                    chk("out_addr", int'(out_addr), a);
                    if (a == N - 1) nxt_done = 1'b1;
                end
            end else if (q_out.size() > 0) begin
                chk("out_hold_addr", int'(out_addr), q_out[0]);
            end
        end
        done_exp = nxt_done;
    end

    function automatic logic pick(input int mode, input logic tog);
        case (mode)
            0:       return 1'b1;
            1:       return tog;
            default: return logic'($urandom_range(1, 0));
        endcase
    endfunction

    task automatic push_frame();
        for (int k = 0; k < N; k++) begin
            q_ld_addr.push_back(bitrev_ref(k, L));
            q_ld_cnt.push_back(k);
        end
        for (int s = 0; s < L; s++) begin
            for (int b = 0; b < HALF; b++) begin
                q_cp_stage.push_back(s);
                q_cp_bfly.push_back(b);
                q_cp_iter.push_back((b == HALF - 1) ? 1 : 0);
            end
        end
        for (int a = 0; a < N; a++) begin
            q_out.push_back(a);
        end
    endtask

    task automatic flush();
        q_ld_addr.delete();
        q_ld_cnt.delete();
        q_cp_stage.delete();
        q_cp_bfly.delete();
        q_cp_iter.delete();
        q_out.delete();
    endtask

    // One frame: start, then per-cycle inputs by mode until done, abort or reset.
    task automatic run_frame(input int ldm, input int cpm, input int outm,
                             input int abort_stage, input int rst_cyc, input bit start_noise);
        bit   fin;
        int   cyc;
        logic tog;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_frame();
        exp_idle = 1'b0;
        fin = 1'b0;
        cyc = 0;
        tog = 1'b0;
        while (!fin) begin
            tog        = !tog;
            input_ena  = pick(ldm, tog);
            bfly_ready = pick(cpm, tog);
            out_ready  = pick(outm, tog);
            start      = start_noise ? logic'($urandom_range(1, 0)) : 1'b0;
            if (abort_stage >= 0 && busy && int'(stage) == abort_stage) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                flush();
                exp_idle = 1'b1;
                fin = 1'b1;
            end else if (rst_cyc >= 0 && cyc == rst_cyc) begin
                n_reset = 1'b0;
                flush();
                exp_idle = 1'b1;
                @(posedge clk); #1;
                @(posedge clk); #1;
                n_reset = 1'b1;
                fin = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
                if (done) begin
                    exp_idle = 1'b1;
                    fin = 1'b1;
                end else if (cyc > 4000) begin
                    tmo_req = 1'b1;
                    abort = 1'b1;
                    @(posedge clk); #1;
                    abort = 1'b0;
                    flush();
                    exp_idle = 1'b1;
                    fin = 1'b1;
                end
            end
        end
        start = 1'b0;
        input_ena  = 1'b1;
        bfly_ready = 1'b1;
        out_ready  = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_reset    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        input_ena  = 1'b0;
        bfly_ready = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_reset    = 1'b1;
        input_ena  = 1'b1;
        bfly_ready = 1'b1;
        out_ready  = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        // gapped load, full-rate compute, toggling backpressure
        run_frame(1, 0, 1, -1, -1, 1'b0);
        // random everything, with start noise while busy
        run_frame(2, 2, 2, -1, -1, 1'b1);
        // abort in stage 3, then a normal frame
        run_frame(0, 0, 0, 3, -1, 1'b0);
        run_frame(2, 0, 2, -1, -1, 1'b0);
        // asynchronous reset mid-compute, then a normal frame
        run_frame(0, 2, 0, -1, 150, 1'b0);
        run_frame(0, 0, 0, -1, -1, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
